ibpl_in_cond: RTL and testbench

Six-channel input conditioning stage for interbackplane input cardlets. It sits between the raw DIOB input pins and the cardlet's internal input bus. Per channel it synchronises the asynchronous pin level, applies a programmable debounce filter and gates the result with the channel enable. It emits clean levels, single-cycle edge strobes, a pulse-stretched activity flag for the front-panel LEDs, and a saturating count of rejected glitches.

---
 rtl/ibpl_in_cond.sv | 137 +++++++++++++
 tb/tb_ibpl_in_cond.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ibpl_in_cond.sv
// Six-channel input conditioning: synchronise, debounce, enable-gate, edge strobes,
// stretched activity flags and a saturating glitch counter.
module ibpl_in_cond #(
    parameter int unsigned CHANNELS       = 6,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE_W     = 8,
    parameter int unsigned STRETCH_CYCLES = 1000000,
    parameter bit          INVERT         = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   diob_in,
    input  logic [CHANNELS-1:0]   input_enable,
    input  logic [DEBOUNCE_W-1:0] debounce_len,
    input  logic                  glitch_clr,
    output logic [CHANNELS-1:0]   in_clean,
    output logic [CHANNELS-1:0]   in_rise,
    output logic [CHANNELS-1:0]   in_fall,
    output logic [CHANNELS-1:0]   in_act,
    output logic [15:0]           glitch_cnt
);

    localparam int unsigned StretchW = $clog2(STRETCH_CYCLES + 1);
    localparam int unsigned GlitchW  = $clog2(CHANNELS + 1);
    localparam logic [StretchW-1:0] StretchLoad = StretchW'(STRETCH_CYCLES);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0]                  s;

    logic [CHANNELS-1:0]                  clean_q, clean_d;
    logic [CHANNELS-1:0]                  rise_q, rise_d;
    logic [CHANNELS-1:0]                  fall_q, fall_d;
    logic [CHANNELS-1:0]                  act_q, act_d;
    logic [CHANNELS-1:0][DEBOUNCE_W-1:0]  cnt_q, cnt_d;
    logic [CHANNELS-1:0][StretchW-1:0]    stretch_q, stretch_d;
    logic [CHANNELS-1:0]                  glitch;
    logic [GlitchW-1:0]                   glitch_sum;
    logic [16:0]                          glitch_total;
    logic [15:0]                          glitch_cnt_q, glitch_cnt_d;
    logic [DEBOUNCE_W-1:0]                neff_m1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= diob_in ^ {CHANNELS{INVERT}};
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A length of 0 behaves as 1, so the commit threshold is never below zero.
    assign neff_m1 = (debounce_len == '0) ? '0 : debounce_len - DEBOUNCE_W'(1);

    always_comb begin
        clean_d    = clean_q;
        cnt_d      = cnt_q;
        rise_d     = '0;
        fall_d     = '0;
        act_d      = '0;
        stretch_d  = stretch_q;
        glitch     = '0;
        glitch_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!input_enable[i]) begin
                clean_d[i] = 1'b0;
                cnt_d[i]   = '0;
            end else if (s[i] != clean_q[i]) begin
                if (cnt_q[i] >= neff_m1) begin
                    clean_d[i] = s[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
                end
            end else if (cnt_q[i] != '0) begin
                cnt_d[i]  = '0;
                glitch[i] = 1'b1;
            end

            // Strobes only on debounced transitions; a disable-induced fall is silent.
            rise_d[i] = input_enable[i] & clean_d[i] & ~clean_q[i];
            fall_d[i] = input_enable[i] & ~clean_d[i] & clean_q[i];

            if (!input_enable[i]) begin
                stretch_d[i] = '0;
            end else if (rise_d[i] || fall_d[i]) begin
                stretch_d[i] = StretchLoad;
            end else if (stretch_q[i] != '0) begin
                stretch_d[i] = stretch_q[i] - StretchW'(1);
            end
            act_d[i] = (stretch_d[i] != '0);

            glitch_sum = glitch_sum + GlitchW'(glitch[i]);
        end
    end

    always_comb begin
        glitch_total = {1'b0, glitch_cnt_q} + 17'(glitch_sum);
        if (glitch_clr) begin
            glitch_cnt_d = '0;
        end else if (glitch_total[16]) begin
            glitch_cnt_d = 16'hFFFF;
        end else begin
            glitch_cnt_d = glitch_total[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clean_q      <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            act_q        <= '0;
            cnt_q        <= '0;
            stretch_q    <= '0;
            glitch_cnt_q <= '0;
        end else begin
            clean_q      <= clean_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            act_q        <= act_d;
            cnt_q        <= cnt_d;
            stretch_q    <= stretch_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign in_clean   = clean_q;
    assign in_rise    = rise_q;
    assign in_fall    = fall_q;
    assign in_act     = act_q;
    assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_ibpl_in_cond.sv
// Directed bench for ibpl_in_cond: inputs change and outputs are checked on the falling edge.
module tb_ibpl_in_cond;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  diob_in;
    logic [5:0]  input_enable;
    logic [7:0]  debounce_len;
    logic        glitch_clr;
    logic [5:0]  in_clean;
    logic [5:0]  in_rise;
    logic [5:0]  in_fall;
    logic [5:0]  in_act;
    logic [15:0] glitch_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibpl_in_cond #(
        .CHANNELS       (6),
        .SYNC_STAGES    (2),
        .DEBOUNCE_W     (8),
        .STRETCH_CYCLES (16),
        .INVERT         (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .diob_in      (diob_in),
        .input_enable (input_enable),
        .debounce_len (debounce_len),
        .glitch_clr   (glitch_clr),
        .in_clean     (in_clean),
        .in_rise      (in_rise),
        .in_fall      (in_fall),
        .in_act       (in_act),
        .glitch_cnt   (glitch_cnt)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        diob_in      = '0;
        input_enable = 6'h3F;
        debounce_len = 8'd4;
        glitch_clr   = 1'b0;
        tick(2);
        chk("rst_clean", 32'(in_clean), 32'h0);
        chk("rst_rise", 32'(in_rise), 32'h0);
        chk("rst_act", 32'(in_act), 32'h0);
        chk("rst_glitch", 32'(glitch_cnt), 32'h0);
        rst = 1'b0;
        tick(3);

        // Step on ch0 with N=4: clean at edge 6, act held 16 cycles.
        diob_in[0] = 1'b1;
        tick(5);
        chk("step_pre", 32'(in_clean[0]), 32'd0);
        tick(1);
        chk("step_clean", 32'(in_clean[0]), 32'd1);
        chk("step_rise", 32'(in_rise[0]), 32'd1);
        chk("step_act", 32'(in_act[0]), 32'd1);
        tick(1);
        chk("step_rise_1cyc", 32'(in_rise[0]), 32'd0);
        tick(14);
        chk("step_act_last", 32'(in_act[0]), 32'd1);
        tick(1);
        chk("step_act_off", 32'(in_act[0]), 32'd0);

        // 3-cycle pulses are rejected and counted.
        diob_in[2] = 1'b1;
        tick(3);
        diob_in[2] = 1'b0;
        tick(5);
        chk("glitch1_cnt", 32'(glitch_cnt), 32'd1);
        chk("glitch1_clean", 32'(in_clean[2]), 32'd0);
        chk("glitch1_act", 32'(in_act[2]), 32'd0);
        diob_in[1] = 1'b1;
        diob_in[3] = 1'b1;
        tick(3);
        diob_in[1] = 1'b0;
        diob_in[3] = 1'b0;
        tick(5);
        chk("glitch3_cnt", 32'(glitch_cnt), 32'd3);
        chk("glitch3_clean", 32'(in_clean[3:1]), 32'd0);
        chk("glitch3_act", 32'(in_act[3:1]), 32'd0);

        // Zero length behaves as 1: 1-cycle pulse passes at latency 3.
        debounce_len = 8'd0;
        tick(1);
        diob_in[5] = 1'b1;
        tick(1);
        diob_in[5] = 1'b0;
        tick(1);
        chk("zero_pre", 32'(in_clean[5]), 32'd0);
        tick(1);
        chk("zero_clean", 32'(in_clean[5]), 32'd1);
        chk("zero_rise", 32'(in_rise[5]), 32'd1);
        tick(1);
        chk("zero_clean_off", 32'(in_clean[5]), 32'd0);
        chk("zero_fall", 32'(in_fall[5]), 32'd1);
        chk("zero_rise_off", 32'(in_rise[5]), 32'd0);
        tick(1);
        chk("zero_fall_off", 32'(in_fall[5]), 32'd0);
        chk("zero_glitch", 32'(glitch_cnt), 32'd3);

        // Enable gating on ch4.
        debounce_len = 8'd4;
        diob_in[4] = 1'b1;
        tick(7);
        chk("en_clean", 32'(in_clean[4]), 32'd1);
        input_enable[4] = 1'b0;
        tick(1);
        chk("dis_clean", 32'(in_clean[4]), 32'd0);
        chk("dis_fall", 32'(in_fall[4]), 32'd0);
        chk("dis_act", 32'(in_act[4]), 32'd0);
        tick(2);
        input_enable[4] = 1'b1;
        tick(3);
        chk("reen_pre", 32'(in_clean[4]), 32'd0);
        tick(1);
        chk("reen_clean", 32'(in_clean[4]), 32'd1);
        chk("reen_rise", 32'(in_rise[4]), 32'd1);

        // Saturation: 4 channels toggling with N=2 give 2 glitches per cycle.
        debounce_len = 8'd2;
        tick(1);
        for (int i = 0; i < 36000; i++) begin
            diob_in = diob_in ^ 6'b101110;
            tick(1);
        end
        tick(5);
        chk("sat_cnt", 32'(glitch_cnt), 32'hFFFF);
        chk("sat_clean", 32'(in_clean & 6'b101110), 32'h0);

        // Clear coinciding with a glitch (glitch lands on edge 4 after the pulse).
        diob_in[1] = 1'b1;
        tick(1);
        diob_in[1] = 1'b0;
        tick(2);
        chk("clr_pre", 32'(glitch_cnt), 32'hFFFF);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        chk("clr_wins", 32'(glitch_cnt), 32'h0);
        tick(3);
        chk("clr_hold", 32'(glitch_cnt), 32'h0);
        diob_in[1] = 1'b1;
        tick(1);
        diob_in[1] = 1'b0;
        tick(6);
        chk("post_clr_glitch", 32'(glitch_cnt), 32'd1);

        // Retrigger: fall strobe when the stretch counter reads 5 reloads it to 16.
        debounce_len = 8'd1;
        tick(1);
        diob_in[3] = 1'b1;
        tick(3);
        chk("retrig_rise", 32'(in_rise[3]), 32'd1);
        tick(9);
        diob_in[3] = 1'b0;
        tick(3);
        chk("retrig_fall", 32'(in_fall[3]), 32'd1);
        chk("retrig_clean", 32'(in_clean[3]), 32'd0);
        tick(4);
        chk("retrig_act_mid", 32'(in_act[3]), 32'd1);
        tick(11);
        chk("retrig_act_last", 32'(in_act[3]), 32'd1);
        tick(1);
        chk("retrig_act_off", 32'(in_act[3]), 32'd0);

        // Reset mid-filter on ch2 (cnt=2), then full latency again.
        debounce_len = 8'd4;
        tick(1);
        diob_in[2] = 1'b1;
        tick(4);
        rst = 1'b1;
        #1;
        chk("midrst_clean", 32'(in_clean), 32'h0);
        chk("midrst_rise", 32'(in_rise), 32'h0);
        chk("midrst_fall", 32'(in_fall), 32'h0);
        chk("midrst_act", 32'(in_act), 32'h0);
        chk("midrst_glitch", 32'(glitch_cnt), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("midrst_pre", 32'(in_clean), 32'h0);
        tick(1);
        chk("midrst_clean_after", 32'(in_clean), 32'h15);
        chk("midrst_rise_after", 32'(in_rise), 32'h15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
